// File: rtl/weight_fetch.sv
// Weight-tile fetcher: reads up to FIFO_DEPTH rows from weight memory and pushes them into the weight FIFO.
// Optional build macro WEIGHT_FETCH_COLMASK_EN zeroes the columns at or beyond numCols in every push.
module weight_fetch #(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_INPUTS = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int ADDR_WIDTH  = 8,
  parameter int CNT_WIDTH   = 8,
  parameter int FIFO_WIDTH  = DATA_WIDTH * FIFO_INPUTS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  baseAddr,
  input  logic [CNT_WIDTH-1:0]   numRows,
  input  logic [CNT_WIDTH-1:0]   numCols,
  output logic                   memEn,
  output logic [ADDR_WIDTH-1:0]  memAddr,
  input  logic [FIFO_WIDTH-1:0]  memData,
  output logic [FIFO_INPUTS-1:0] fifoEn,
  output logic [FIFO_WIDTH-1:0]  weightOut,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CNT_WIDTH-1:0]  rows_q, rows_d;
  logic                  s1_valid_q, s1_valid_d;
  logic                  s1_rd_q, s1_rd_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [FIFO_WIDTH-1:0] data_q, data_d;
  logic                  fetch_rd;

`ifdef WEIGHT_FETCH_COLMASK_EN
  logic [CNT_WIDTH-1:0]  cols_q, cols_d;
`else
  logic                  unused_cols;
  assign unused_cols = ^numCols;
`endif

  // Control FSM: FETCH walks the row counter, DRAIN covers the two-stage read/push pipeline.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    rows_d   = rows_q;
    fetch_rd = 1'b0;
`ifdef WEIGHT_FETCH_COLMASK_EN
    cols_d   = cols_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = baseAddr;
          rows_d  = (numRows > CNT_WIDTH'(FIFO_DEPTH)) ? CNT_WIDTH'(FIFO_DEPTH) : numRows;
`ifdef WEIGHT_FETCH_COLMASK_EN
          cols_d  = (numCols > CNT_WIDTH'(FIFO_INPUTS)) ? CNT_WIDTH'(FIFO_INPUTS) : numCols;
`endif
          cnt_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        fetch_rd = (cnt_q < rows_q);
        if (cnt_q == CNT_WIDTH'(FIFO_DEPTH - 1)) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q == CNT_WIDTH'(1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Rows that were not read still push, but as zeros.
  always_comb begin
    s1_valid_d = (state_q == FETCH);
    s1_rd_d    = fetch_rd;
    s2_valid_d = s1_valid_q;
    data_d     = s1_rd_q ? memData : '0;
`ifdef WEIGHT_FETCH_COLMASK_EN
    for (int c = 0; c < FIFO_INPUTS; c++) begin
      if (CNT_WIDTH'(c) >= cols_q) data_d[FIFO_WIDTH-1-c*DATA_WIDTH -: DATA_WIDTH] = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      base_q     <= '0;
      rows_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_rd_q    <= 1'b0;
      s2_valid_q <= 1'b0;
      data_q     <= '0;
`ifdef WEIGHT_FETCH_COLMASK_EN
      cols_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      base_q     <= base_d;
      rows_q     <= rows_d;
      s1_valid_q <= s1_valid_d;
      s1_rd_q    <= s1_rd_d;
      s2_valid_q <= s2_valid_d;
      data_q     <= data_d;
`ifdef WEIGHT_FETCH_COLMASK_EN
      cols_q     <= cols_d;
`endif
    end
  end

  // Outputs are gated by reset so they read zero in the reset cycle itself.
  assign memEn     = fetch_rd && !reset;
  assign memAddr   = memEn ? (base_q + ADDR_WIDTH'(cnt_q)) : '0;
  assign fifoEn    = {FIFO_INPUTS{s2_valid_q && !reset}};
  assign weightOut = (s2_valid_q && !reset) ? data_q : '0;
  assign busy      = ((state_q == FETCH) || (state_q == DRAIN)) && !reset;
  assign done      = (state_q == DONE) && !reset;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_weight_fetch.sv
// Directed bench for weight_fetch: table of tile loads checked cycle by cycle, plus reset and restart sequences.
module tb_weight_fetch;

`ifdef WEIGHT_FETCH_COLMASK_EN
  localparam bit MASK = 1'b1;
`else
  localparam bit MASK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [7:0]  num_rows = '0;
  logic [7:0]  num_cols = '0;
  logic        mem_en;
  logic [7:0]  mem_addr;
  logic [31:0] mem_data = '0;
  logic [3:0]  fifo_en;
  logic [31:0] weight_out;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  weight_fetch dut (
    .clk(clk), .reset(reset), .start(start), .baseAddr(base_addr),
    .numRows(num_rows), .numCols(num_cols), .memEn(mem_en), .memAddr(mem_addr),
    .memData(mem_data), .fifoEn(fifo_en), .weightOut(weight_out),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_row(input logic [7:0] a);
    if (a == 8'h40) return 32'h11223344;
    return {a, ~a, a + 8'h01, 8'h5A};
  endfunction

  // Memory model: one-cycle read latency, garbage when not strobed.
  always @(posedge clk) mem_data <= mem_en ? mem_row(mem_addr) : 32'h0BADF00D;

  typedef struct packed {
    logic [7:0]   base;
    logic [7:0]   rows;
    logic [7:0]   cols;
    logic [3:0]   restart_k;
    logic [3:0]   en;      // bit 3 = row 0
    logic [31:0]  addrs;   // byte 3 = row 0
    logic [127:0] pushes;  // word 3 = push 0
  } vec_t;

  vec_t vecs [7];

  function automatic logic [46:0] pack_out(input logic e, input logic [7:0] a, input logic [3:0] f,
                                           input logic [31:0] w, input logic b, input logic d);
    return {e, a, f, w, b, d};
  endfunction

  task automatic check(input string name, input int cyc, input logic [46:0] exp);
    logic [46:0] got;
    got = pack_out(mem_en, mem_addr, fifo_en, weight_out, busy, done);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [46:0] expect_at(input vec_t v, input int k);
    logic e, b, d;
    logic [7:0] a;
    logic [3:0] f;
    logic [31:0] w;
    e = 1'b0; a = '0; f = '0; w = '0;
    if (k >= 1 && k <= 4) begin
      e = v.en[4-k];
      a = e ? v.addrs[31-8*(k-1) -: 8] : 8'h00;
    end
    if (k >= 3 && k <= 6) begin
      f = 4'hF;
      w = v.pushes[127-32*(k-3) -: 32];
    end
    b = (k >= 1 && k <= 6);
    d = (k == 7);
    return pack_out(e, a, f, w, b, d);
  endfunction

  task automatic run_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    @(negedge clk);
    base_addr = v.base; num_rows = v.rows; num_cols = v.cols;
    start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("vec%0d", idx), k, expect_at(v, k));
      start = (k == int'(v.restart_k));
    end
    start = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h10, 8'd4, 8'd4, 4'd2, 4'b1111, 32'h10111213,
                {32'h10EF115A, 32'h11EE125A, 32'h12ED135A, 32'h13EC145A}};
    vecs[1] = '{8'h20, 8'd2, 8'd4, 4'd0, 4'b1100, 32'h20210000,
                {32'h20DF215A, 32'h21DE225A, 32'h0, 32'h0}};
    vecs[2] = '{8'hFE, 8'd4, 8'd4, 4'd0, 4'b1111, 32'hFEFF0001,
                {32'hFE01FF5A, 32'hFF00005A, 32'h00FF015A, 32'h01FE025A}};
    vecs[3] = '{8'h30, 8'd0, 8'd4, 4'd5, 4'b0000, 32'h0,
                {32'h0, 32'h0, 32'h0, 32'h0}};
    vecs[4] = '{8'h50, 8'd9, 8'd9, 4'd0, 4'b1111, 32'h50515253,
                {32'h50AF515A, 32'h51AE525A, 32'h52AD535A, 32'h53AC545A}};
    vecs[5] = '{8'h40, 8'd1, 8'd2, 4'd0, 4'b1000, 32'h40000000,
                {(MASK ? 32'h11220000 : 32'h11223344), 32'h0, 32'h0, 32'h0}};
    vecs[6] = '{8'h60, 8'd2, 8'd1, 4'd0, 4'b1100, 32'h60610000,
                {(MASK ? 32'h60000000 : 32'h609F615A), (MASK ? 32'h61000000 : 32'h619E625A), 32'h0, 32'h0}};

    // Reset with start held high: outputs stay zero during reset and the cycle after.
    start = 1'b1; base_addr = 8'h10; num_rows = 8'd4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_hold", i, 47'h0);
    end
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("post_reset", 0, 47'h0);

    for (int i = 0; i < 7; i++) run_vec(i);

    // Restart pulse then reset mid-load: no further pushes, busy or done.
    @(negedge clk);
    base_addr = 8'h10; num_rows = 8'd4; num_cols = 8'd4;
    start = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k <= 3) check("abort_pre", k, expect_at(vecs[0], k));
      start = (k == 2);
      if (k == 4) begin
        reset = 1'b1;
        #1 check("abort_in_reset", k, 47'h0);
      end else if (k >= 5) begin
        reset = 1'b0;
        check("abort_after", k, 47'h0);
      end
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL abort_state got=%0d exp=0", dbg_state);
    end

    // Start in the DONE cycle is ignored; held into IDLE it is accepted.
    @(negedge clk);
    base_addr = 8'h10; num_rows = 8'd4; num_cols = 8'd4;
    start = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k <= 7) check("done_start", k, expect_at(vecs[0], k));
      if (k == 7) start = 1'b1;
      if (k == 8) check("done_start_ignored", k, 47'h0);
      if (k == 9) begin
        start = 1'b0;
        check("idle_start_taken", k, expect_at(vecs[0], 1));
      end
    end
    repeat (10) @(negedge clk);
    check("final_idle", 0, 47'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/weight_fetch.md
WEIGHT_FETCH -- requirements
Module: weight_fetch

Interface
REQ-001: Parameter DATA_WIDTH, default 8, bits per weight.
REQ-002: Parameter FIFO_INPUTS, default 4, columns per row; FIFO_WIDTH = DATA_WIDTH*FIFO_INPUTS.
REQ-003: Parameter FIFO_DEPTH, default 4, rows pushed per load.
REQ-004: Parameter ADDR_WIDTH, default 8, weight-memory address width.
REQ-005: Parameter CNT_WIDTH, default 8, width of numRows/numCols.
REQ-006: clk  input  1  single clock; all state updates on rising edge.
REQ-007: reset  input  1  synchronous, active-high reset.
REQ-008: start  input  1  load request, sampled only in IDLE.
REQ-009: baseAddr  input  ADDR_WIDTH  memory address of row 0.
REQ-010: numRows  input  CNT_WIDTH  valid rows in tile.
REQ-011: numCols  input  CNT_WIDTH  valid columns in tile.
REQ-012: memEn  output  1  memory read strobe.
REQ-013: memAddr  output  ADDR_WIDTH  memory read address.
REQ-014: memData  input  FIFO_WIDTH  read data, valid exactly one cycle after memEn; MSB is leftmost column.
REQ-015: fifoEn  output  FIFO_INPUTS  per-column shift enable to the weight FIFO.
REQ-016: weightOut  output  FIFO_WIDTH  row pushed to the weight FIFO; MSB is leftmost column.
REQ-017: busy  output  1  high while a load is in progress.
REQ-018: done  output  1  one-cycle completion pulse.

Function
REQ-019: FSM states IDLE, FETCH, DRAIN, DONE; IDLE->FETCH on start; FETCH->DRAIN after FIFO_DEPTH cycles; DRAIN->DONE after 2 cycles; DONE->IDLE unconditionally.
REQ-020: On start in IDLE (cycle S), baseAddr, numRows (clamped to FIFO_DEPTH), and numCols (clamped to FIFO_INPUTS) are latched.
REQ-021: In FETCH cycle S+1+r (r = 0..FIFO_DEPTH-1), memAddr = baseAddr+r modulo 2^ADDR_WIDTH; memEn = 1 only if r < numRows.
REQ-022: Row r is pushed in cycle S+3+r: fifoEn = all ones, weightOut = registered memData if r < numRows, else all zeros.
REQ-023: Pushes occupy exactly FIFO_DEPTH consecutive cycles; fifoEn = 0 and weightOut = 0 in every other cycle.
REQ-024: busy = 1 in cycles S+1..S+FIFO_DEPTH+2; done = 1 only in cycle S+FIFO_DEPTH+3, with busy = 0.
REQ-025: start while not IDLE is ignored with no effect on the current load.
REQ-026: numRows = 0 produces FIFO_DEPTH all-zero pushes, no memEn, and normal done timing.
REQ-027: start asserted in the DONE cycle is ignored; start is accepted the following cycle (IDLE).
REQ-028: memAddr = 0 whenever memEn = 0.

Reset
REQ-029: reset forces IDLE and clears all latched parameters and pipeline registers.
REQ-030: During reset and in the cycle after it, memEn, memAddr, fifoEn, weightOut, busy, and done are 0.
REQ-031: Reset mid-load aborts the load: no further push occurs, and done is not pulsed.

Configuration
REQ-032: Macro WEIGHT_FETCH_COLMASK_EN defined: in each push, column c (c = 0 leftmost, bits FIFO_WIDTH-1-c*DATA_WIDTH downward) is forced to zero when c >= numCols.
REQ-033: Macro WEIGHT_FETCH_COLMASK_EN undefined: numCols is ignored and all columns pass memData unmodified.

Verification
REQ-034: Reset, then start with baseAddr=0x10, numRows=4, numCols=4 -> memAddr 0x10..0x13 in S+1..S+4; 4 pushes of mem rows in S+3..S+6; done in S+7.
REQ-035: numRows=2 -> memEn only in S+1..S+2; pushes 3 and 4 are zero.
REQ-036: baseAddr=0xFE, numRows=4 -> memAddr sequence 0xFE, 0xFF, 0x00, 0x01.
REQ-037: With WEIGHT_FETCH_COLMASK_EN defined, memData=0x11223344 and numCols=2 -> weightOut=0x11220000; without the macro -> 0x11223344.
REQ-038: start re-pulsed in S+2, then reset asserted in S+4 -> second start ignored; fifoEn, busy, and done are 0 from S+5 onward.
REQ-039: numRows=0 -> 4 zero pushes in S+3..S+6, memEn never asserted, done in S+7.
